// File: rtl/fetch_unit_pkg.sv
// Purpose: shared CPU constants (opcodes, functs) and the fetch state encoding.
// Latency: none, declarations only.
// Backpressure: not applicable.
package fetch_unit_pkg;

    localparam logic [5:0] RTYPE_OP = 6'h00;
    localparam logic [5:0] J_OP     = 6'h02;
    localparam logic [5:0] JAL_OP   = 6'h03;
    localparam logic [5:0] BEQ_OP   = 6'h04;
    localparam logic [5:0] BNE_OP   = 6'h05;
    localparam logic [5:0] ADDI_OP  = 6'h08;
    localparam logic [5:0] XORI_OP  = 6'h0E;
    localparam logic [5:0] LW_OP    = 6'h23;
    localparam logic [5:0] SW_OP    = 6'h2B;

    localparam logic [5:0] JR_FUNCT  = 6'h08;
    localparam logic [5:0] ADD_FUNCT = 6'h20;
    localparam logic [5:0] SUB_FUNCT = 6'h22;
    localparam logic [5:0] SLT_FUNCT = 6'h2A;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    // Word-offset branch displacement, sign-extended to 32 bits.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// Purpose: combinational next-PC selection for J/JAL/BEQ/BNE/JR, else pc+4.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is taken.
module next_pc_calc
    import fetch_unit_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc_plus4,
    input  logic        branch_taken,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc
);

    logic [5:0] op;
    logic [5:0] fn;

    assign op = instr[31:26];
    assign fn = instr[5:0];

    // Branch polarity is resolved upstream; only the taken flag matters here.
    always_comb begin
        next_pc = pc_plus4;
        if (op == J_OP || op == JAL_OP) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if ((op == BEQ_OP || op == BNE_OP) && branch_taken) begin
            next_pc = pc_plus4 + branch_offset(instr[15:0]);
        end else if (op == RTYPE_OP && fn == JR_FUNCT) begin
            next_pc = jr_target;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Purpose: PC register and IDLE/FETCH/EXEC sequencer; FETCH_MISALIGN_TRAP_EN adds a JR misalign halt.
// Latency: imem_req in cycle N with imem_rdy high gives instr_valid in N+1; >= 2 cycles per instruction.
// Backpressure: FETCH holds imem_req/addr until imem_rdy; EXEC holds instr/pc until exec_done.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 imem_req,
    output logic [31:0]          imem_addr,
    input  logic                 imem_rdy,
    input  logic [31:0]          imem_data,
    output logic                 instr_valid,
    output logic [31:0]          instr,
    output logic [5:0]           opcode,
    output logic [5:0]           funct,
    output logic [31:0]          pc,
    output logic [31:0]          pc_plus4,
    input  logic                 exec_done,
    input  logic                 branch_taken,
    input  logic [31:0]          jr_target,
    output logic [CNT_WIDTH-1:0] retired
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic                 misaligned
`endif
);

    fetch_state_t state, next_state;
    logic [31:0]  next_pc;
    logic [31:0]  pc_d;
    logic         retire;

    assign opcode    = instr[31:26];
    assign funct     = instr[5:0];
    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;
    assign retire    = (state == EXEC) && exec_done;

    next_pc_calc u_next_pc_calc (
        .instr        (instr),
        .pc_plus4     (pc_plus4),
        .branch_taken (branch_taken),
        .jr_target    (jr_target),
        .next_pc      (next_pc)
    );

`ifdef FETCH_MISALIGN_TRAP_EN
    logic jr_misalign;

    assign jr_misalign = (opcode == RTYPE_OP) && (funct == JR_FUNCT) && (jr_target[1:0] != 2'b00);
    assign misaligned  = (state == HALT);
    // A trapping JR keeps the faulting pc for debug.
    assign pc_d        = jr_misalign ? pc : next_pc;
`else
    assign pc_d        = next_pc & ~32'h3;
`endif

    always_comb begin
        next_state  = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state)
            IDLE: next_state = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_rdy) next_state = EXEC;
            end
            EXEC: begin
                instr_valid = 1'b1;
                if (exec_done) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    next_state = jr_misalign ? HALT : FETCH;
`else
                    next_state = FETCH;
`endif
                end
            end
            HALT: next_state = HALT;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            instr   <= 32'h0;
            retired <= '0;
        end else begin
            state <= next_state;
            if (state == FETCH && imem_rdy) instr <= imem_data;
            if (retire) begin
                pc      <= pc_d;
                retired <= retired + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized instruction stream
// checked against a spec-level next-PC model.
module tb_fetch_unit;

    localparam logic [5:0] T_RTYPE = 6'h00, T_J = 6'h02, T_JAL = 6'h03, T_BEQ = 6'h04;
    localparam logic [5:0] T_BNE = 6'h05, T_ADDI = 6'h08, T_LW = 6'h23, T_BAD = 6'h3F;
    localparam logic [5:0] T_JR = 6'h08, T_ADD = 6'h20;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rdy;
    logic [31:0] imem_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        exec_done;
    logic        branch_taken;
    logic [31:0] jr_target;
    logic [31:0] retired;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] m_pc;
    logic [31:0] m_ret;
    bit          m_halt;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdy     (imem_rdy),
        .imem_data    (imem_data),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .opcode       (opcode),
        .funct        (funct),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .exec_done    (exec_done),
        .branch_taken (branch_taken),
        .jr_target    (jr_target),
        .retired      (retired)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misaligned   (misaligned)
`endif
    );

    function automatic logic [31:0] mk_j(input logic [5:0] op, input logic [25:0] idx);
        return {op, idx};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd1, 5'd2, imm};
    endfunction

    function automatic logic [31:0] mk_r(input logic [5:0] fn);
        return {T_RTYPE, 5'd3, 5'd4, 5'd5, 5'd0, fn};
    endfunction

    // Spec-level next-PC rule, written with plain integer arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] w,
                                             input bit bt, input logic [31:0] jt);
        logic [31:0] p4;
        logic [31:0] r;
        int          disp;
        p4   = cur + 32'd4;
        disp = int'($signed(w[15:0])) * 4;
        if (w[31:26] == T_J || w[31:26] == T_JAL)
            r = (p4 & 32'hF000_0000) | ({6'b0, w[25:0]} * 32'd4);
        else if ((w[31:26] == T_BEQ || w[31:26] == T_BNE) && bt)
            r = p4 + 32'(disp);
        else if (w[31:26] == T_RTYPE && w[5:0] == T_JR)
            r = jt;
        else
            r = p4;
`ifndef FETCH_MISALIGN_TRAP_EN
        r = r & 32'hFFFF_FFFC;
`endif
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        m_pc   = 32'h0;
        m_ret  = 32'h0;
        m_halt = 1'b0;
    endtask

    // One full fetch/execute transaction with stall cycles on both handshakes.
    task automatic run_instr(input logic [31:0] w, input bit bt, input logic [31:0] jt,
                             input int rd, input int dd);
        int          n;
        logic [31:0] old_pc;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (imem_req !== 1'b1) begin
            bad++;
            $display("FAIL req_timeout got=%b want=1", imem_req);
        end
        total++;
        if (imem_addr !== m_pc) begin
            bad++;
            $display("FAIL fetch_addr got=%h want=%h", imem_addr, m_pc);
        end
        for (int i = 0; i < rd; i++) begin
            tick();
            total++;
            if (imem_req !== 1'b1 || imem_addr !== m_pc || instr_valid !== 1'b0) begin
                bad++;
                $display("FAIL stall req=%b addr=%h vld=%b want 1 %h 0", imem_req, imem_addr, instr_valid, m_pc);
            end
        end
        imem_rdy  = 1'b1;
        imem_data = w;
        tick();
        imem_rdy  = 1'b0;
        imem_data = $urandom;
        total++;
        if (instr_valid !== 1'b1 || instr !== w || imem_req !== 1'b0) begin
            bad++;
            $display("FAIL latch vld=%b instr=%h req=%b want 1 %h 0", instr_valid, instr, imem_req, w);
        end
        total++;
        if (opcode !== w[31:26] || funct !== w[5:0] || pc !== m_pc || pc_plus4 !== m_pc + 32'd4) begin
            bad++;
            $display("FAIL fields op=%h fn=%h pc=%h p4=%h want %h %h %h %h",
                     opcode, funct, pc, pc_plus4, w[31:26], w[5:0], m_pc, m_pc + 32'd4);
        end
        for (int i = 0; i < dd; i++) begin
            exec_done    = 1'b0;
            branch_taken = 1'($urandom);
            imem_rdy     = 1'($urandom);
            tick();
            imem_rdy = 1'b0;
            total++;
            if (instr_valid !== 1'b1 || instr !== w || pc !== m_pc || retired !== m_ret) begin
                bad++;
                $display("FAIL exec_hold vld=%b instr=%h pc=%h ret=%0d want 1 %h %h %0d",
                         instr_valid, instr, pc, retired, w, m_pc, m_ret);
            end
        end
        exec_done    = 1'b1;
        branch_taken = bt;
        jr_target    = jt;
        tick();
        exec_done    = 1'b0;
        branch_taken = 1'($urandom);
        jr_target    = $urandom;
        old_pc = m_pc;
        m_ret  = m_ret + 32'd1;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (w[31:26] == T_RTYPE && w[5:0] == T_JR && jt[1:0] != 2'b00) m_halt = 1'b1;
`endif
        if (!m_halt) m_pc = ref_next(old_pc, w, bt, jt);
        total++;
        if (retired !== m_ret) begin
            bad++;
            $display("FAIL retired got=%0d want=%0d", retired, m_ret);
        end
        total++;
        if (instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL valid_one_cycle got=%b want=0", instr_valid);
        end
        total++;
        if (imem_req !== !m_halt || imem_addr !== m_pc) begin
            bad++;
            $display("FAIL next_fetch req=%b addr=%h want %b %h", imem_req, imem_addr, !m_halt, m_pc);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #3;
        total++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0 || retired !== 32'h0 || instr !== 32'h0) begin
            bad++;
            $display("FAIL reset_state req=%b vld=%b pc=%h ret=%0d instr=%h want 0 0 0 0 0",
                     imem_req, instr_valid, pc, retired, instr);
        end
        tick();
        reset  = 1'b0;
        m_pc   = 32'h0;
        m_ret  = 32'h0;
        m_halt = 1'b0;
        total++;
        if (imem_req !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_req got=%b want=0", imem_req);
        end
        tick();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            bad++;
            $display("FAIL idle_to_fetch req=%b addr=%h want 1 0", imem_req, imem_addr);
        end
    endtask

    task automatic test_basic;
        run_instr(mk_i(T_ADDI, 16'h0005), 1'b0, 32'h0, 0, 0);
        total++;
        if (imem_addr !== 32'h4 || retired !== 32'd1) begin
            bad++;
            $display("FAIL basic_addi addr=%h ret=%0d want 4 1", imem_addr, retired);
        end
    endtask

    task automatic test_stall;
        run_instr(mk_r(T_ADD), 1'b1, 32'h0, 3, 2);
    endtask

    task automatic test_branch;
        run_instr(mk_j(T_J, 26'h4), 1'b0, 32'h0, 0, 0);
        run_instr(mk_i(T_BEQ, 16'hFFFF), 1'b1, 32'h0, 0, 0);
        total++;
        if (pc !== 32'h10) begin
            bad++;
            $display("FAIL beq_taken got=%h want=00000010", pc);
        end
        run_instr(mk_i(T_BEQ, 16'hFFFF), 1'b0, 32'h0, 1, 0);
        total++;
        if (pc !== 32'h14) begin
            bad++;
            $display("FAIL beq_not_taken got=%h want=00000014", pc);
        end
    endtask

    task automatic test_jump;
        run_instr(mk_r(T_JR), 1'b0, 32'h1000_0000, 0, 0);
        run_instr(mk_j(T_J, 26'h40), 1'b0, 32'h0, 0, 1);
        total++;
        if (pc !== 32'h1000_0100) begin
            bad++;
            $display("FAIL j_target got=%h want=10000100", pc);
        end
        run_instr(mk_r(T_JR), 1'b0, 32'h0000_2000, 0, 0);
        total++;
        if (pc !== 32'h0000_2000) begin
            bad++;
            $display("FAIL jr_target got=%h want=00002000", pc);
        end
    endtask

    task automatic test_wrap;
        run_instr(mk_r(T_JR), 1'b0, 32'hFFFF_FFFC, 0, 0);
        run_instr(mk_r(T_ADD), 1'b0, 32'h0, 0, 0);
        total++;
        if (pc !== 32'h0) begin
            bad++;
            $display("FAIL pc_wrap got=%h want=00000000", pc);
        end
    endtask

    task automatic test_random;
        logic [31:0] w;
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 9))
                0: w = mk_j(T_J, 26'($urandom));
                1: w = mk_j(T_JAL, 26'($urandom));
                2: w = mk_i(T_BEQ, 16'($urandom));
                3: w = mk_i(T_BNE, 16'($urandom));
                4: w = mk_r(T_JR);
                5: w = mk_r(T_ADD);
                6: w = mk_i(T_ADDI, 16'($urandom));
                7: w = mk_i(T_LW, 16'($urandom));
                8: w = mk_i(T_BAD, 16'($urandom));
                default: w = $urandom;
            endcase
            run_instr(w, 1'($urandom), $urandom & 32'hFFFF_FFFC,
                      $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_mid_fetch;
        run_instr(mk_r(T_JR), 1'b0, 32'h0000_0800, 0, 0);
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (imem_req !== 1'b0 || pc !== 32'h0 || retired !== 32'h0 || instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_fetch req=%b pc=%h ret=%0d vld=%b want 0 0 0 0",
                     imem_req, pc, retired, instr_valid);
        end
        tick();
        reset  = 1'b0;
        m_pc   = 32'h0;
        m_ret  = 32'h0;
        m_halt = 1'b0;
    endtask

    task automatic test_misalign;
        run_instr(mk_r(T_JR), 1'b0, 32'h0000_2002, 0, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 5; i++) begin
            imem_rdy  = 1'b1;
            exec_done = 1'b1;
            tick();
            total++;
            if (misaligned !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0 || retired !== 32'd1) begin
                bad++;
                $display("FAIL halt misal=%b req=%b vld=%b pc=%h ret=%0d want 1 0 0 0 1",
                         misaligned, imem_req, instr_valid, pc, retired);
            end
        end
        imem_rdy  = 1'b0;
        exec_done = 1'b0;
        do_reset();
        total++;
        if (misaligned !== 1'b0) begin
            bad++;
            $display("FAIL halt_cleared got=%b want=0", misaligned);
        end
`else
        total++;
        if (pc !== 32'h0000_2000) begin
            bad++;
            $display("FAIL jr_forced_align got=%h want=00002000", pc);
        end
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b0;
        imem_rdy     = 1'b0;
        imem_data    = 32'h0;
        exec_done    = 1'b0;
        branch_taken = 1'b0;
        jr_target    = 32'h0;
        m_pc         = 32'h0;
        m_ret        = 32'h0;
        m_halt       = 1'b0;
        #2;
        test_reset();
        test_basic();
        test_stall();
        test_branch();
        test_jump();
        test_wrap();
        test_random();
        test_reset_mid_fetch();
        test_misalign();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
